// File: rtl/mem_pkg.sv
// Shared types for the data memory controller: access sizes, FSM states, word geometry.
package mem_pkg;
  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10
  } mem_size_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STORE_RESP,
    ST_RMW,
    ST_ERR_RESP
  } dmc_state_t;
endpackage

// File: rtl/mem_lane_align.sv
// Lane steering between RAM words and byte/half/word data; purely combinational, no flow control.
// Load path extracts and extends; store path merges new data into the old word.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [31:0] ld_word,
  input  logic [1:0]  lane,
  input  mem_size_t   size,
  input  logic        is_unsigned,
  output logic [31:0] ld_data,
  input  logic [31:0] st_old,
  input  logic [31:0] st_new,
  output logic [31:0] st_merged
);
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    ld_byte = ld_word[{lane, 3'b000} +: 8];
    ld_half = lane[1] ? ld_word[31:16] : ld_word[15:0];
    case (size)
      MEM_BYTE: ld_data = is_unsigned ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      MEM_HALF: ld_data = is_unsigned ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default:  ld_data = ld_word;
    endcase
  end

  always_comb begin
    st_merged = st_old;
    case (size)
      MEM_BYTE: st_merged[{lane, 3'b000} +: 8] = st_new[7:0];
      MEM_HALF: begin
        if (lane[1]) st_merged[31:16] = st_new[15:0];
        else         st_merged[15:0]  = st_new[15:0];
      end
      default:  st_merged = st_new;
    endcase
  end
endmodule

// File: rtl/data_mem_ctrl.sv
// Byte-addressed load/store front-end onto a 1-cycle single-port word RAM; responds 1 cycle after
// accept (2 for sub-word stores via read-modify-write); ready only in IDLE, response has no backpressure.
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int DEPTH      = 2**16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_req_valid,
  output logic                     o_req_ready,
  input  logic                     i_req_we,
  input  logic [1:0]               i_req_size,
  input  logic                     i_req_unsigned,
  input  logic [31:0]              i_req_addr,
  input  logic [DATA_WIDTH-1:0]    i_req_wdata,
  output logic                     o_resp_valid,
  output logic [DATA_WIDTH-1:0]    o_resp_rdata,
  output logic                     o_resp_err,
  output logic [$clog2(DEPTH)-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0]    o_ram_data,
  output logic                     o_ram_we,
  input  logic [DATA_WIDTH-1:0]    i_ram_data
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(WORD_BYTES);

  dmc_state_t            state, state_nxt;
  logic                  cap_we, cap_uns;
  mem_size_t             cap_size;
  logic [LW-1:0]         cap_lane;
  logic [AW-1:0]         cap_addr;
  logic [DATA_WIDTH-1:0] cap_wdata;

  logic                  accept, req_err;
  logic [AW-1:0]         req_word;
  logic [DATA_WIDTH-1:0] ld_data, st_merged;

  assign o_req_ready = (state == ST_IDLE) && !i_rst;
  assign accept      = i_req_valid && o_req_ready;
  assign req_word    = i_req_addr[AW+LW-1:LW];

  always_comb begin
    req_err = 1'b0;
    case (mem_size_t'(i_req_size))
      MEM_BYTE: req_err = 1'b0;
      MEM_HALF: req_err = i_req_addr[0];
      MEM_WORD: req_err = (i_req_addr[1:0] != 2'b00);
      default:  req_err = 1'b1;
    endcase
    if ((i_req_addr >> (AW + LW)) != 32'd0) req_err = 1'b1;
  end

  mem_lane_align u_align (
    .ld_word     (i_ram_data),
    .lane        (cap_lane),
    .size        (cap_size),
    .is_unsigned (cap_uns),
    .ld_data     (ld_data),
    .st_old      (i_ram_data),
    .st_new      (cap_wdata),
    .st_merged   (st_merged)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      cap_we    <= 1'b0;
      cap_uns   <= 1'b0;
      cap_size  <= MEM_BYTE;
      cap_lane  <= '0;
      cap_addr  <= '0;
      cap_wdata <= '0;
    end else begin
      state <= state_nxt;
      if (accept && !req_err) begin
        cap_we    <= i_req_we;
        cap_uns   <= i_req_unsigned;
        cap_size  <= mem_size_t'(i_req_size);
        cap_lane  <= i_req_addr[LW-1:0];
        cap_addr  <= req_word;
        cap_wdata <= i_req_wdata;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    o_resp_valid = 1'b0;
    o_resp_err   = 1'b0;
    o_resp_rdata = '0;
    o_ram_we     = 1'b0;
    o_ram_addr   = cap_addr;
    o_ram_data   = '0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (req_err) begin
            state_nxt = ST_ERR_RESP;
          end else begin
            o_ram_addr = req_word;
            if (!i_req_we) begin
              state_nxt = ST_LOAD;
            end else if (i_req_size == MEM_WORD) begin
              o_ram_we   = 1'b1;
              o_ram_data = i_req_wdata;
              state_nxt  = ST_STORE_RESP;
            end else begin
              state_nxt = ST_RMW;
            end
          end
        end
      end
      ST_LOAD: begin
        o_resp_valid = 1'b1;
        o_resp_rdata = ld_data;
        state_nxt    = ST_IDLE;
      end
      ST_RMW: begin
        // i_ram_data is the old word read during the accept cycle
        o_ram_we   = 1'b1;
        o_ram_data = st_merged;
        state_nxt  = ST_STORE_RESP;
      end
      ST_STORE_RESP: begin
        o_resp_valid = 1'b1;
        state_nxt    = ST_IDLE;
      end
      ST_ERR_RESP: begin
        o_resp_valid = 1'b1;
        o_resp_err   = 1'b1;
        state_nxt    = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Reset kills an in-flight RMW write immediately, not at the next edge
    if (i_rst) begin
      o_ram_we     = 1'b0;
      o_ram_addr   = '0;
      o_ram_data   = '0;
      o_resp_valid = 1'b0;
      o_resp_err   = 1'b0;
      o_resp_rdata = '0;
    end
  end

  logic unused_cap_we;
  assign unused_cap_we = cap_we;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl with a write-first word RAM model and a response scoreboard.
module tb_data_mem_ctrl;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_uns = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [15:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_we;
  logic [31:0] ram_rdata = 32'd0;

  logic [31:0] mem [0:65535];

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          cy;
  } exp_t;
  exp_t exp_q[$];

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= ram_we ? ram_wdata : mem[ram_addr];
  end

  data_mem_ctrl dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_req_valid    (req_valid),
    .o_req_ready    (req_ready),
    .i_req_we       (req_we),
    .i_req_size     (req_size),
    .i_req_unsigned (req_uns),
    .i_req_addr     (req_addr),
    .i_req_wdata    (req_wdata),
    .o_resp_valid   (resp_valid),
    .o_resp_rdata   (resp_rdata),
    .o_resp_err     (resp_err),
    .o_ram_addr     (ram_addr),
    .o_ram_data     (ram_wdata),
    .o_ram_we       (ram_we),
    .i_ram_data     (ram_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every response must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("resp_unexpected", {31'b0, resp_valid}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("resp_rdata", resp_rdata, e.rd);
        chk("resp_err", {31'b0, resp_err}, {31'b0, e.err});
        chk("resp_cycle", cyc, e.cy);
      end
    end
  end

  // Drive one request (valid stays high afterwards); returns at the negedge after acceptance
  task automatic issue(input string tag, input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rd, input logic exp_err, input int lat,
                       input logic wr_now, input logic wr_rmw, input logic [31:0] wr_data);
    int n;
    exp_t e;
    req_valid = 1'b1;
    req_we    = we;
    req_size  = size;
    req_uns   = uns;
    req_addr  = addr;
    req_wdata = wdata;
    #1;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (req_ready !== 1'b1) begin
      chk({tag, "_accept_timeout"}, {31'b0, req_ready}, 32'd1);
      return;
    end
    e.rd = exp_rd; e.err = exp_err; e.cy = cyc + lat;
    exp_q.push_back(e);
    chk({tag, "_we_accept"}, {31'b0, ram_we}, {31'b0, wr_now});
    if (!exp_err) chk({tag, "_addr_accept"}, {16'b0, ram_addr}, {16'b0, addr[17:2]});
    if (wr_now) chk({tag, "_wdata_accept"}, ram_wdata, wr_data);
    @(negedge clk);
    chk({tag, "_ready_busy"}, {31'b0, req_ready}, 32'd0);
    chk({tag, "_we_next"}, {31'b0, ram_we}, {31'b0, wr_rmw});
    if (wr_rmw) begin
      chk({tag, "_rmw_data"}, ram_wdata, wr_data);
      chk({tag, "_rmw_addr"}, {16'b0, ram_addr}, {16'b0, addr[17:2]});
      @(negedge clk);
      chk({tag, "_ready_stresp"}, {31'b0, req_ready}, 32'd0);
    end
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_ram_we", {31'b0, ram_we}, 32'd0);
    chk("rst_ram_addr", {16'b0, ram_addr}, 32'd0);
    chk("rst_ram_data", ram_wdata, 32'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", {31'b0, req_ready}, 32'd1);
    @(negedge clk);

    // Preload word 0x10 then sign/zero-extended loads
    issue("sw_pre", 1'b1, MEM_WORD, 1'b0, 32'h40, 32'h8899AABB, 32'h0, 1'b0, 1, 1'b1, 1'b0, 32'h8899AABB);
    idle(1);
    issue("lb_41",  1'b0, MEM_BYTE, 1'b0, 32'h41, 32'h0, 32'hFFFFFFAA, 1'b0, 1, 1'b0, 1'b0, 32'h0);
    idle(1);
    issue("lbu_41", 1'b0, MEM_BYTE, 1'b1, 32'h41, 32'h0, 32'h000000AA, 1'b0, 1, 1'b0, 1'b0, 32'h0);
    idle(1);
    issue("lh_42",  1'b0, MEM_HALF, 1'b0, 32'h42, 32'h0, 32'hFFFF8899, 1'b0, 1, 1'b0, 1'b0, 32'h0);
    idle(1);
    issue("lhu_42", 1'b0, MEM_HALF, 1'b1, 32'h42, 32'h0, 32'h00008899, 1'b0, 1, 1'b0, 1'b0, 32'h0);
    idle(1);
    issue("lb_43",  1'b0, MEM_BYTE, 1'b0, 32'h43, 32'h0, 32'hFFFFFF88, 1'b0, 1, 1'b0, 1'b0, 32'h0);
    idle(1);

    // Word store, then read-modify-write stores
    issue("sw_40", 1'b1, MEM_WORD, 1'b0, 32'h40, 32'h12345678, 32'h0, 1'b0, 1, 1'b1, 1'b0, 32'h12345678);
    idle(1);
    issue("lw_40", 1'b0, MEM_WORD, 1'b0, 32'h40, 32'h0, 32'h12345678, 1'b0, 1, 1'b0, 1'b0, 32'h0);
    idle(1);
    issue("sb_43", 1'b1, MEM_BYTE, 1'b0, 32'h43, 32'h123456EE, 32'h0, 1'b0, 2, 1'b0, 1'b1, 32'hEE345678);
    idle(1);
    issue("sh_40", 1'b1, MEM_HALF, 1'b0, 32'h40, 32'h9876CAFE, 32'h0, 1'b0, 2, 1'b0, 1'b1, 32'hEE34CAFE);
    idle(1);
    issue("lw_40b", 1'b0, MEM_WORD, 1'b0, 32'h40, 32'h0, 32'hEE34CAFE, 1'b0, 1, 1'b0, 1'b0, 32'h0);
    idle(1);

    // Error cases: no RAM write, rdata 0
    issue("err_lw41", 1'b0, MEM_WORD, 1'b0, 32'h41, 32'h0, 32'h0, 1'b1, 1, 1'b0, 1'b0, 32'h0);
    idle(1);
    issue("err_lh43", 1'b0, MEM_HALF, 1'b0, 32'h43, 32'h0, 32'h0, 1'b1, 1, 1'b0, 1'b0, 32'h0);
    idle(1);
    issue("err_sz11", 1'b1, 2'b11,    1'b0, 32'h40, 32'h5, 32'h0, 1'b1, 1, 1'b0, 1'b0, 32'h0);
    idle(1);
    issue("err_oor",  1'b1, MEM_WORD, 1'b0, 32'h00040000, 32'h7, 32'h0, 1'b1, 1, 1'b0, 1'b0, 32'h0);
    idle(1);

    // Back-to-back with valid held high between requests
    issue("b2b_lb40",  1'b0, MEM_BYTE, 1'b0, 32'h40, 32'h0, 32'hFFFFFFFE, 1'b0, 1, 1'b0, 1'b0, 32'h0);
    issue("b2b_sb41",  1'b1, MEM_BYTE, 1'b0, 32'h41, 32'hFFFFFF55, 32'h0, 1'b0, 2, 1'b0, 1'b1, 32'hEE3455FE);
    issue("b2b_lhu40", 1'b0, MEM_HALF, 1'b1, 32'h40, 32'h0, 32'h000055FE, 1'b0, 1, 1'b0, 1'b0, 32'h0);
    issue("b2b_sw44",  1'b1, MEM_WORD, 1'b0, 32'h44, 32'hA5A5A5A5, 32'h0, 1'b0, 1, 1'b1, 1'b0, 32'hA5A5A5A5);
    issue("b2b_lw44",  1'b0, MEM_WORD, 1'b0, 32'h44, 32'h0, 32'hA5A5A5A5, 1'b0, 1, 1'b0, 1'b0, 32'h0);
    issue("b2b_err",   1'b0, MEM_HALF, 1'b0, 32'h41, 32'h0, 32'h0, 1'b1, 1, 1'b0, 1'b0, 32'h0);
    idle(1);
    issue("lw_40c", 1'b0, MEM_WORD, 1'b0, 32'h40, 32'h0, 32'hEE3455FE, 1'b0, 1, 1'b0, 1'b0, 32'h0);
    idle(2);

    // Reset during the RMW write of SB 0x11 at 0x40
    req_valid = 1'b1; req_we = 1'b1; req_size = MEM_BYTE; req_uns = 1'b0;
    req_addr = 32'h40; req_wdata = 32'h11;
    #1;
    chk("rst_rmw_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    chk("rst_rmw_we_before", {31'b0, ram_we}, 32'd1);
    rst = 1'b1;
    req_valid = 1'b0;
    #1;
    chk("rst_rmw_we_drop", {31'b0, ram_we}, 32'd0);
    chk("rst_rmw_ready_held", {31'b0, req_ready}, 32'd0);
    repeat (3) @(negedge clk);
    chk("rst_rmw_ready_still", {31'b0, req_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_rmw_ready_release", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    issue("lw_after_rst", 1'b0, MEM_WORD, 1'b0, 32'h40, 32'h0, 32'hEE3455FE, 1'b0, 1, 1'b0, 1'b0, 32'h0);
    idle(1);

    n = 0;
    while (exp_q.size() != 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
